// File: rtl/pm_pkg.sv
// pm_pkg: shared definitions for the pattern_match_ctrl controller.
//   pm_state_t : controller state (IDLE, SCAN, DONE)
//   PM_PW      : default pattern width in bits
//   PM_CW      : default match counter / target width
package pm_pkg;

  localparam int PM_PW = 3;
  localparam int PM_CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } pm_state_t;

endpackage

// File: rtl/pattern_match_ctrl_if.sv
// pattern_match_ctrl_if: configuration valid/ready channel.
//   cfg_valid   : configuration offered (master -> slave)
//   cfg_ready   : controller can accept (slave -> master)
//   cfg_pattern : pattern, MSB is the oldest bit
//   cfg_target  : number of matches that completes a run
//   cfg_overlap : 1 = overlapping matches count, 0 = refill after a match
interface pattern_match_ctrl_if #(
  parameter int PW = 3,
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_pattern;
  logic [CW-1:0] cfg_target;
  logic          cfg_overlap;

  modport master (
    output cfg_valid, cfg_pattern, cfg_target, cfg_overlap,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_target, cfg_overlap,
    output cfg_ready
  );
endinterface

// File: rtl/pm_shift_match.sv
// pm_shift_match: PW-bit serial shift register, fill counter and comparator.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero shift register and fill counter (new run)
//   shift_en  : shift a in this cycle
//   refill    : restart the fill counter instead of advancing it
//   a         : serial data bit
//   pattern   : pattern to compare against, MSB oldest
//   match     : combinational; the bit being shifted in completes a match
module pm_shift_match
  import pm_pkg::*;
#(
  parameter int PW = PM_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          refill,
  input  logic          a,
  input  logic [PW-1:0] pattern,
  output logic          match
);

  localparam int FW = $clog2(PW + 1);
  localparam logic [FW-1:0] FULL = FW'(PW);

  logic [PW-1:0] s_reg;
  logic [PW-1:0] s_next;
  logic [FW-1:0] fill_reg;
  logic [FW-1:0] fill_next;
  logic [PW-1:0] bit_eq;

  assign s_next    = {s_reg[PW-2:0], a};
  // Saturates at PW so a long run never overflows the counter.
  assign fill_next = (fill_reg == FULL) ? FULL : fill_reg + FW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_cmp
      assign bit_eq[gi] = ~(s_next[gi] ^ pattern[gi]);
    end
  endgenerate

  // Stale bits left in s_reg after a refill cannot match: fill gates them.
  assign match = (fill_next == FULL) && (&bit_eq);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s_reg    <= '0;
      fill_reg <= '0;
    end else if (shift_en) begin
      s_reg    <= s_next;
      fill_reg <= refill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl: run-to-target serial pattern detector controller.
//   clk, rst : clock, synchronous active-high reset
//   cfg      : configuration channel (slave side)
//   abort    : cancel the run (SCAN or DONE)
//   a        : serial data, sampled each cycle in SCAN
//   sign     : registered one-cycle match pulse
//   count    : matches in the current / last run
//   busy     : scanning
//   done     : run complete, held until done_ack
//   done_ack : release DONE
module pattern_match_ctrl
  import pm_pkg::*;
#(
  parameter int PW = PM_PW,
  parameter int CW = PM_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  pattern_match_ctrl_if.slave  cfg,
  input  logic                 abort,
  input  logic                 a,
  output logic                 sign,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done,
  input  logic                 done_ack
);

  pm_state_t     state_reg, state_next;
  logic [PW-1:0] pattern_reg;
  logic [CW-1:0] target_reg;
  logic          overlap_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          sign_reg, sign_next;
  logic          accept;
  logic          shift_en;
  logic          refill;
  logic          match;

  pm_shift_match #(.PW(PW)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (shift_en),
    .refill   (refill),
    .a        (a),
    .pattern  (pattern_reg),
    .match    (match)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sign_next  = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    refill     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg.cfg_valid) begin
          accept     = 1'b1;
          count_next = '0;
          state_next = (cfg.cfg_target == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        // abort wins over a coincident match: no pulse, count untouched.
        if (abort) begin
          state_next = IDLE;
        end else begin
          shift_en = 1'b1;
          if (match) begin
            sign_next  = 1'b1;
            count_next = count_reg + CW'(1);
            refill     = ~overlap_reg;
            if (count_next == target_reg) state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort || done_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      sign_reg    <= 1'b0;
      pattern_reg <= '0;
      target_reg  <= '0;
      overlap_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sign_reg  <= sign_next;
      if (accept) begin
        pattern_reg <= cfg.cfg_pattern;
        target_reg  <= cfg.cfg_target;
        overlap_reg <= cfg.cfg_overlap;
      end
    end
  end

  assign cfg.cfg_ready = (state_reg == IDLE);
  assign busy          = (state_reg == SCAN);
  assign done          = (state_reg == DONE);
  assign sign          = sign_reg;
  assign count         = count_reg;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb_pattern_match_ctrl: directed bench for pattern_match_ctrl with a
// behavioural reference model and a per-cycle compare process.
module tb_pattern_match_ctrl;

  localparam int PW = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          a;
  logic          done_ack;
  logic          sign;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  pattern_match_ctrl_if #(.PW(PW), .CW(CW)) cfg_bus ();

  pattern_match_ctrl #(.PW(PW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg_bus),
    .abort    (abort),
    .a        (a),
    .sign     (sign),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .done_ack (done_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0=waiting for config, 1=scanning, 2=finished.
  int          m_phase = 0;
  int          m_count = 0;
  bit          m_sign  = 1'b0;
  int          m_fresh = 0;
  int unsigned m_hist  = 0;
  int unsigned m_pat   = 0;
  int          m_tgt   = 0;
  bit          m_ovl   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sign",      int'(sign),              int'(m_sign));
      check("count",     int'(count),             m_count);
      check("busy",      int'(busy),              int'(m_phase == 1));
      check("done",      int'(done),              int'(m_phase == 2));
      check("cfg_ready", int'(cfg_bus.cfg_ready), int'(m_phase == 0));
    end
  end

  // One clock: apply inputs, advance the model on the edge, return 1 time unit later.
  task automatic step(input bit r, input bit cv, input int pat, input int tgt,
                      input bit ov, input bit ab, input bit bit_a, input bit ack);
    rst                 = r;
    cfg_bus.cfg_valid   = cv;
    cfg_bus.cfg_pattern = PW'(pat);
    cfg_bus.cfg_target  = CW'(tgt);
    cfg_bus.cfg_overlap = ov;
    abort               = ab;
    a                   = bit_a;
    done_ack            = ack;
    @(posedge clk);
    m_sign = 1'b0;
    if (r) begin
      m_phase = 0; m_count = 0; m_fresh = 0; m_hist = 0;
    end else if (m_phase == 0) begin
      if (cv) begin
        m_pat = pat; m_tgt = tgt; m_ovl = ov;
        m_count = 0; m_fresh = 0; m_hist = 0;
        m_phase = (tgt == 0) ? 2 : 1;
        $display("cfg accepted: pattern=%b target=%0d overlap=%0d", PW'(pat), tgt, ov);
      end
    end else if (m_phase == 1) begin
      if (ab) begin
        m_phase = 0;
      end else begin
        m_hist  = (m_hist << 1) | int'(bit_a);
        m_fresh = m_fresh + 1;
        if (m_fresh >= PW && (m_hist & ((1 << PW) - 1)) == m_pat) begin
          m_sign  = 1'b1;
          m_count = m_count + 1;
          if (!m_ovl) m_fresh = 0;
          if (m_count == m_tgt) m_phase = 2;
        end
      end
    end else begin
      if (ab || ack) m_phase = 0;
    end
    #1;
  endtask

  task automatic idle_cyc();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input int pat, input int tgt, input bit ov);
    step(0, 1, pat, tgt, ov, 0, 0, 0);
  endtask
  task automatic bit_in(input bit b);
    step(0, 0, 0, 0, 0, 0, b, 0);
  endtask
  task automatic ack();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    $display("done_ack issued");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle_cyc();
    check("rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);

    // 101, target 2, overlapping: pulses after bits 3 and 5
    cfg(3'b101, 2, 1);
    bit_in(1); bit_in(0); bit_in(1);
    check("t1_sign1", int'(sign), 1);
    check("t1_count1", int'(count), 1);
    bit_in(0);
    check("t1_sign_drop", int'(sign), 0);
    bit_in(1);
    check("t1_sign2", int'(sign), 1);
    check("t1_count2", int'(count), 2);
    check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    ack();

    // 101, target 2, non-overlapping: one pulse, then 1,0,1 gives the second
    cfg(3'b101, 2, 0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    check("t2_count1", int'(count), 1);
    check("t2_busy", int'(busy), 1);
    bit_in(1); bit_in(0); bit_in(1);
    check("t2_sign2", int'(sign), 1);
    check("t2_count2", int'(count), 2);
    check("t2_done", int'(done), 1);
    ack();

    // target 0: straight to DONE
    cfg(3'b111, 0, 1);
    check("t3_done", int'(done), 1);
    check("t3_busy", int'(busy), 0);
    check("t3_count", int'(count), 0);
    idle_cyc();
    ack();
    check("t3_ready", int'(cfg_bus.cfg_ready), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1); // done_ack in IDLE: no effect

    // abort on a matching bit; stray cfg_valid during SCAN
    cfg(3'b110, 3, 1);
    bit_in(1); bit_in(1); bit_in(0);
    check("t4_count1", int'(count), 1);
    step(0, 1, 3'b000, 0, 0, 0, 1, 0);
    step(0, 1, 3'b000, 0, 0, 0, 1, 0);
    check("t4_stray_cfg", int'(busy), 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("t4_abort_sign", int'(sign), 0);
    check("t4_abort_ready", int'(cfg_bus.cfg_ready), 1);
    check("t4_abort_count", int'(count), 1);
    step(0, 0, 0, 0, 0, 1, 1, 0); // abort in IDLE ignored

    // reset mid-run with count 5, then 000 needs three fresh zeros
    cfg(3'b111, 20, 1);
    repeat (7) bit_in(1);
    check("t5_count5", int'(count), 5);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    check("t5_rst_count", int'(count), 0);
    check("t5_rst_sign", int'(sign), 0);
    check("t5_rst_ready", int'(cfg_bus.cfg_ready), 1);
    cfg(3'b000, 1, 0);
    bit_in(0); bit_in(0);
    check("t5_no_early", int'(sign), 0);
    bit_in(0);
    check("t5_match", int'(sign), 1);
    check("t5_done", int'(done), 1);

    // hold DONE, then back-to-back reconfiguration after ack
    for (int i = 0; i < 10; i++) bit_in(i[0]);
    check("t6_hold_done", int'(done), 1);
    check("t6_hold_count", int'(count), 1);
    ack();
    cfg(3'b010, 1, 1);
    check("t6_reconfig", int'(busy), 1);
    bit_in(0); bit_in(1); bit_in(0);
    check("t6_done", int'(done), 1);
    ack();
    idle_cyc();
    idle_cyc();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
